// File: rtl/gsim_pkg.sv
// gsim_pkg -- shared definitions for the banded Gauss-Seidel solver.
//   state_t        : solver FSM states
//   C_DIAG..C_OFF3 : magnitudes of the matrix bands (diag 20, off1 -13, off2 6, off3 -1)
//   DEF_*          : default parameter values for gsim_gen2
package gsim_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOAD    = 2'd1,
      S_COMPUTE = 2'd2,
      S_OUTPUT  = 2'd3
   } state_t;

   localparam int C_DIAG = 20;
   localparam int C_OFF1 = 13;
   localparam int C_OFF2 = 6;
   localparam int C_OFF3 = 1;

   localparam int DEF_N    = 16;
   localparam int DEF_B_W  = 16;
   localparam int DEF_X_W  = 32;
   localparam int DEF_FRAC = 16;
   localparam int DEF_ITER = 64;
   localparam int DEF_EPS  = 0;

endpackage

// File: rtl/gsim_div20.sv
// gsim_div20 -- combinational signed divide by 20, round to nearest,
// ties away from zero.
//   i_num : signed dividend, W bits
//   o_quo : signed quotient, W bits
module gsim_div20
   import gsim_pkg::*;
#(
   parameter int W = DEF_X_W + 6
)
(
   input  logic [W-1:0] i_num,
   output logic [W-1:0] o_quo
);

   localparam logic [W:0] DIV  = (W+1)'(C_DIAG);
   localparam logic [W:0] HALF = (W+1)'(C_DIAG / 2);

   logic         w_neg;
   logic [W:0]   w_mag;
   logic [W-1:0] w_qmag;

   // Work on the magnitude (one extra bit so the most negative input
   // still has a representable magnitude), then restore the sign.
   assign w_neg  = i_num[W-1];
   assign w_mag  = w_neg ? (~{1'b1, i_num} + 1'b1) : {1'b0, i_num};
   assign w_qmag = W'((w_mag + HALF) / DIV);
   assign o_quo  = w_neg ? (~w_qmag + 1'b1) : w_qmag;

endmodule

// File: rtl/gsim_gen2.sv
// gsim_gen2 -- iterative Gauss-Seidel solver for A*x = b, where A is the
// N x N symmetric band matrix (20 | -13 | 6 | -1).
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   in_en     : b_in valid (accepted in IDLE/LOAD only)
//   b_in      : signed integer b_i, streamed in index order 0..N-1
//   out_valid : x_out valid, high for N consecutive cycles per solve
//   x_out     : signed Q(X_W-FRAC).FRAC x_i, index order 0..N-1; 0 when idle
//   busy      : high while computing or streaming results
//   converged : last solve stopped on the EPS test rather than the ITER cap
module gsim_gen2
   import gsim_pkg::*;
#(
   parameter int N    = DEF_N,
   parameter int B_W  = DEF_B_W,
   parameter int X_W  = DEF_X_W,
   parameter int FRAC = DEF_FRAC,
   parameter int ITER = DEF_ITER,
   parameter int EPS  = DEF_EPS
)
(
   input  logic           clk,
   input  logic           reset,
   input  logic           in_en,
   input  logic [B_W-1:0] b_in,
   output logic           out_valid,
   output logic [X_W-1:0] x_out,
   output logic           busy,
   output logic           converged
);

   localparam int ACC_W = X_W + 6;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int PAD_W = $clog2(N + 6);
   localparam int SW_W  = $clog2(ITER + 1) + 1;
   localparam int D_W   = X_W + 1;

   localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N - 1);
   localparam logic signed [ACC_W-1:0] K1       = ACC_W'(C_OFF1);
   localparam logic signed [ACC_W-1:0] K2       = ACC_W'(C_OFF2);
   localparam logic signed [ACC_W-1:0] K3       = ACC_W'(C_OFF3);

   state_t                  r_state;
   state_t                  w_next;
   logic [IDX_W-1:0]        r_idx;
   logic [SW_W-1:0]         r_sweep;
   logic [D_W-1:0]          r_maxd;
   logic                    r_conv;
   logic signed [B_W-1:0]   r_b [N];
   logic signed [X_W-1:0]   r_x [N];

   logic signed [ACC_W-1:0] w_xw [N+6];
   logic [PAD_W-1:0]        w_pi;
   logic signed [ACC_W-1:0] w_bi;
   logic signed [ACC_W-1:0] w_acc;
   logic [ACC_W-1:0]        w_quo;
   logic signed [X_W-1:0]   w_xnew;
   logic signed [D_W-1:0]   w_diff;
   logic [D_W-1:0]          w_absd;
   logic [D_W-1:0]          w_maxd;
   logic                    w_last;
   logic                    w_conv_hit;
   logic                    w_cap_hit;
   logic                    w_exit;

   function automatic logic signed [X_W-1:0] sat_x(input logic signed [ACC_W-1:0] v);
      logic [ACC_W-X_W:0] top;
      top = v[ACC_W-1:X_W-1];
      if (top == {(ACC_W-X_W+1){v[ACC_W-1]}})
         return v[X_W-1:0];
      else if (v[ACC_W-1])
         return {1'b1, {(X_W-1){1'b0}}};
      else
         return {1'b0, {(X_W-1){1'b1}}};
   endfunction

   // x is viewed through a zero-padded window (3 on each side) so that
   // out-of-range neighbours read as 0 without per-tap bound checks.
   always_comb begin
      for (int k = 0; k < N + 6; k++) w_xw[k] = '0;
      for (int k = 0; k < N; k++) w_xw[k + 3] = ACC_W'(r_x[k]);
      w_pi  = PAD_W'(r_idx) + PAD_W'(3);
      w_bi  = ACC_W'(r_b[r_idx]) <<< FRAC;
      w_acc = w_bi
            + K1 * (w_xw[w_pi - PAD_W'(1)] + w_xw[w_pi + PAD_W'(1)])
            - K2 * (w_xw[w_pi - PAD_W'(2)] + w_xw[w_pi + PAD_W'(2)])
            + K3 * (w_xw[w_pi - PAD_W'(3)] + w_xw[w_pi + PAD_W'(3)]);
   end

   gsim_div20 #(.W(ACC_W)) u_div20 (
      .i_num (w_acc),
      .o_quo (w_quo)
   );

   assign w_xnew     = sat_x($signed(w_quo));
   assign w_diff     = {w_xnew[X_W-1], w_xnew} - {r_x[r_idx][X_W-1], r_x[r_idx]};
   assign w_absd     = w_diff[D_W-1] ? D_W'(-w_diff) : D_W'(w_diff);
   assign w_maxd     = (w_absd > r_maxd) ? w_absd : r_maxd;
   assign w_last     = (r_idx == LAST_IDX);
   assign w_conv_hit = (w_maxd <= D_W'(EPS));
   assign w_cap_hit  = ((r_sweep + SW_W'(1)) == SW_W'(ITER));
   // Convergence wins when it coincides with the sweep cap.
   assign w_exit     = (r_state == S_COMPUTE) && w_last && (w_conv_hit || w_cap_hit);

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // In IDLE r_idx is 0, so w_last there means N == 1 and the first
   // sample is also the last one.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (in_en) w_next = w_last ? S_COMPUTE : S_LOAD;
         S_LOAD:    if (in_en && w_last) w_next = S_COMPUTE;
         S_COMPUTE: if (w_exit) w_next = S_OUTPUT;
         S_OUTPUT:  if (w_last) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx   <= '0;
         r_sweep <= '0;
         r_maxd  <= '0;
         r_conv  <= 1'b0;
         for (int k = 0; k < N; k++) begin
            r_b[k] <= '0;
            r_x[k] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_en) begin
                  r_b[0]  <= $signed(b_in);
                  r_idx   <= w_last ? '0 : IDX_W'(1);
                  r_conv  <= 1'b0;
                  r_sweep <= '0;
                  r_maxd  <= '0;
                  for (int k = 0; k < N; k++) r_x[k] <= '0;
               end
            end
            S_LOAD: begin
               if (in_en) begin
                  r_b[r_idx] <= $signed(b_in);
                  r_idx      <= w_last ? '0 : r_idx + 1'b1;
               end
            end
            S_COMPUTE: begin
               r_x[r_idx] <= w_xnew;
               if (w_last) begin
                  r_idx   <= '0;
                  r_maxd  <= '0;
                  r_sweep <= r_sweep + 1'b1;
                  if (w_exit) r_conv <= w_conv_hit;
               end else begin
                  r_idx  <= r_idx + 1'b1;
                  r_maxd <= w_maxd;
               end
            end
            S_OUTPUT: begin
               r_idx <= w_last ? '0 : r_idx + 1'b1;
            end
            default: r_idx <= '0;
         endcase
      end
   end

   assign out_valid = (r_state == S_OUTPUT);
   assign x_out     = out_valid ? r_x[r_idx] : '0;
   assign busy      = (r_state == S_COMPUTE) || (r_state == S_OUTPUT);
   assign converged = r_conv;

endmodule

// File: tb/tb_gsim_gen2.sv
// tb_gsim_gen2 -- self-checking bench for gsim_gen2. Three instances:
// u_dut (N=16, ITER=64), u_dut1 (N=1), u_dut2 (N=16, ITER=1).
// A plain-arithmetic Gauss-Seidel model supplies expected results.
module tb_gsim_gen2;

   localparam int NB = 16;
   localparam longint XMAX = 64'sd2147483647;
   localparam longint XMIN = -XMAX - 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        drv_en;
   logic [15:0] b_in;
   int          sel;

   logic        en0, en1, en2;
   logic        ov0, ov1, ov2, bz0, bz1, bz2, cv0, cv1, cv2;
   logic [31:0] x0, x1, x2;
   logic        mv, mb, mc;
   logic [31:0] mx;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   assign en0 = drv_en && (sel == 0);
   assign en1 = drv_en && (sel == 1);
   assign en2 = drv_en && (sel == 2);

   always_comb begin
      case (sel)
         1:       begin mv = ov1; mb = bz1; mc = cv1; mx = x1; end
         2:       begin mv = ov2; mb = bz2; mc = cv2; mx = x2; end
         default: begin mv = ov0; mb = bz0; mc = cv0; mx = x0; end
      endcase
   end

   gsim_gen2 #(.N(16), .B_W(16), .X_W(32), .FRAC(16), .ITER(64), .EPS(0)) u_dut (
      .clk(clk), .reset(reset), .in_en(en0), .b_in(b_in),
      .out_valid(ov0), .x_out(x0), .busy(bz0), .converged(cv0));

   gsim_gen2 #(.N(1), .B_W(16), .X_W(32), .FRAC(16), .ITER(64), .EPS(0)) u_dut1 (
      .clk(clk), .reset(reset), .in_en(en1), .b_in(b_in),
      .out_valid(ov1), .x_out(x1), .busy(bz1), .converged(cv1));

   gsim_gen2 #(.N(16), .B_W(16), .X_W(32), .FRAC(16), .ITER(1), .EPS(0)) u_dut2 (
      .clk(clk), .reset(reset), .in_en(en2), .b_in(b_in),
      .out_valid(ov2), .x_out(x2), .busy(bz2), .converged(cv2));

   task automatic chk(input string tag, input longint got, input longint exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint amat(input int d);
      case (d)
         0:       return 20;
         1:       return -13;
         2:       return 6;
         3:       return -1;
         default: return 0;
      endcase
   endfunction

   // Reference: x_i = (b_i*2^16 - sum_{j!=i} A_ij x_j) / 20, rounded
   // half away from zero, saturated, in place, until max delta <= 0.
   task automatic ref_solve(input longint b[NB], input int n, input int iter,
                            output longint x[NB], output int sweeps, output bit conv);
      longint s, q, d, maxd;
      for (int i = 0; i < NB; i++) x[i] = 0;
      sweeps = 0;
      conv   = 1'b0;
      for (int sw = 1; sw <= iter && !conv; sw++) begin
         maxd = 0;
         for (int i = 0; i < n; i++) begin
            s = b[i] * 65536;
            for (int dd = 1; dd <= 3; dd++) begin
               if (i - dd >= 0) s -= amat(dd) * x[i - dd];
               if (i + dd < n)  s -= amat(dd) * x[i + dd];
            end
            q = (s >= 0) ? (s + 10) / 20 : -((-s + 10) / 20);
            if (q > XMAX) q = XMAX;
            if (q < XMIN) q = XMIN;
            d = (q > x[i]) ? q - x[i] : x[i] - q;
            if (d > maxd) maxd = d;
            x[i] = q;
         end
         sweeps = sw;
         if (maxd <= 0) conv = 1'b1;
      end
   endtask

   task automatic do_solve(input int s, input longint b[NB], input bit gap, input bit inj,
                           input bit res, output longint xs[NB]);
      int     n, iter, k, first, cnt, hold_bad, sw, dd;
      bit     cv, cv_seen;
      longint xm[NB];
      real    r, acc;
      n    = (s == 1) ? 1 : NB;
      iter = (s == 2) ? 1 : 64;
      ref_solve(b, n, iter, xm, sw, cv);
      for (int i = 0; i < NB; i++) xs[i] = 0;
      sel = s;
      for (int i = 0; i < n; i++) begin
         drv_en = 1'b1;
         b_in   = b[i][15:0];
         @(negedge clk);
         if (gap && i == 7) begin
            drv_en = 1'b0;
            repeat (3) @(negedge clk);
         end
      end
      drv_en = 1'b0;
      chk($sformatf("s%0d_busy_start", s), longint'(mb), 1);
      k = 1; first = -1; cnt = 0; hold_bad = 0; cv_seen = 1'b0;
      while (k < 3000) begin
         if (mv) begin
            if (first < 0) first = k;
            if (cnt < NB) xs[cnt] = longint'($signed(mx));
            cv_seen = mc;
            cnt++;
            drv_en = 1'b0;
         end else begin
            if (mx != 0) hold_bad++;
            if (first >= 0) break;
            if (inj) begin
               drv_en = 1'b1;
               b_in   = 16'($urandom);
            end
         end
         @(negedge clk);
         k++;
      end
      drv_en = 1'b0;
      chk($sformatf("s%0d_latency", s), first, sw * n + 1);
      chk($sformatf("s%0d_valid_count", s), cnt, n);
      chk($sformatf("s%0d_converged", s), longint'(cv_seen), longint'(cv));
      chk($sformatf("s%0d_conv_hold", s), longint'(mc), longint'(cv));
      chk($sformatf("s%0d_idle_zero", s), hold_bad, 0);
      for (int i = 0; i < n; i++)
         chk($sformatf("s%0d_x%0d", s, i), xs[i], xm[i]);
      if (res) begin
         r = 0.0;
         for (int i = 0; i < n; i++) begin
            acc = -real'(b[i]);
            for (int j = 0; j < n; j++) begin
               dd = (i > j) ? i - j : j - i;
               if (dd <= 3) acc += real'(amat(dd)) * real'(xs[j]) / 65536.0;
            end
            r += acc * acc;
         end
         chk($sformatf("s%0d_residual_ok", s), (r < 1e-6) ? 1 : 0, 1);
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      longint b[NB], xa[NB], xb[NB];
      int     diff, seen;

      reset = 1'b1; drv_en = 1'b0; b_in = '0; sel = 0;
      repeat (3) @(negedge clk);
      chk("rst_valid", longint'(ov0), 0);
      chk("rst_xout", longint'(x0), 0);
      chk("rst_busy", longint'(bz0), 0);
      chk("rst_conv", longint'(cv0), 0);
      chk("rst_valid_n1", longint'(ov1), 0);
      chk("rst_busy_it1", longint'(bz2), 0);
      reset = 1'b0;
      @(negedge clk);

      // all zeros: one sweep, converged, latency 17
      for (int i = 0; i < NB; i++) b[i] = 0;
      do_solve(0, b, 1'b0, 1'b0, 1'b1, xa);

      // random b, back to back
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < NB; i++) b[i] = longint'($urandom_range(0, 1000)) - 500;
         do_solve(0, b, 1'b0, 1'b0, 1'b1, xa);
      end

      // same b with a 3-cycle gap after sample 7, then with in_en during compute
      do_solve(0, b, 1'b1, 1'b0, 1'b0, xb);
      diff = 0;
      for (int i = 0; i < NB; i++) if (xb[i] != xa[i]) diff++;
      chk("gap_same_result", diff, 0);
      do_solve(0, b, 1'b0, 1'b1, 1'b0, xb);
      diff = 0;
      for (int i = 0; i < NB; i++) if (xb[i] != xa[i]) diff++;
      chk("inj_same_result", diff, 0);

      // extreme b values
      for (int i = 0; i < NB; i++) b[i] = 32767;
      do_solve(0, b, 1'b0, 1'b0, 1'b0, xb);
      for (int i = 0; i < NB; i++) b[i] = -32768;
      do_solve(0, b, 1'b0, 1'b0, 1'b0, xb);
      for (int i = 0; i < NB; i++) b[i] = (i % 2 == 0) ? 32767 : -32768;
      do_solve(0, b, 1'b0, 1'b0, 1'b0, xb);

      // N=1, b=20 -> x = 1.0
      for (int i = 0; i < NB; i++) b[i] = 0;
      b[0] = 20;
      do_solve(1, b, 1'b0, 1'b0, 1'b0, xb);
      chk("n1_x_one", xb[0], 64'sh10000);
      b[0] = longint'($urandom_range(0, 60000)) - 30000;
      do_solve(1, b, 1'b0, 1'b0, 1'b0, xb);

      // ITER=1: single sweep, not converged
      for (int i = 0; i < NB; i++) b[i] = longint'($urandom_range(0, 1000)) - 500;
      b[0] = 1000;
      do_solve(2, b, 1'b0, 1'b0, 1'b0, xb);

      // reset in the middle of a solve
      sel = 0;
      for (int i = 0; i < NB; i++) begin
         drv_en = 1'b1;
         b_in   = 16'($urandom);
         @(negedge clk);
      end
      drv_en = 1'b0;
      repeat (20) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", longint'(mb), 0);
      chk("abort_valid", longint'(mv), 0);
      chk("abort_conv", longint'(mc), 0);
      chk("abort_xout", longint'(mx), 0);
      seen = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (mv || mb) seen++;
      end
      chk("abort_quiet", seen, 0);
      for (int i = 0; i < NB; i++) b[i] = longint'($urandom_range(0, 1000)) - 500;
      do_solve(0, b, 1'b0, 1'b0, 1'b1, xa);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
